mute_ramp_ctrl: RTL and testbench

Click-free mute sequencer for the channel-strip mute stage. It replaces a hard mute with a timed gain ramp and drives the sample path. On a mute request it waits for a zero crossing of the audio (or a timeout), then ramps gain linearly to 0; unmute ramps back to unity the same way. It sits in the processing chain in place of a bare mute, one sample per `clk_48` cycle.

---
 rtl/mute_ramp_ctrl.sv | 145 ++++++++++++++
 tb/tb_mute_ramp_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mute_ramp_ctrl.sv
// Click-free mute sequencer: zero-crossing wait then linear gain ramp on the sample path.
// Optional zero-crossing wait states are built when MUTE_ZC_WAIT_EN is defined.
module mute_ramp_ctrl #(
    parameter int unsigned RAMP_LEN_LOG2 = 6,
    parameter int unsigned ZC_TIMEOUT    = 480
) (
    input  logic               clk_48,
    input  logic               reset,
    input  logic               mute,
    input  logic signed [15:0] muteIn,
    output logic signed [15:0] muteOut,
    output logic               muted,
    output logic               busy
);

    localparam int unsigned L  = RAMP_LEN_LOG2;
    localparam int unsigned PW = 18 + L;
    localparam logic [L:0] G_ONE = {{L{1'b0}}, 1'b1};
    localparam logic [L:0] G_TOP = {1'b0, {L{1'b1}}};

    typedef enum logic [2:0] {
        MUTED    = 3'd0,
        UNMUTED  = 3'd1,
        RAMP_DN  = 3'd2,
        RAMP_UP  = 3'd3
`ifdef MUTE_ZC_WAIT_EN
        ,
        WAIT_DN  = 3'd4,
        WAIT_UP  = 3'd5
`endif
    } state_t;

    state_t      state, state_n;
    logic [L:0]  g, g_n;
    logic        muted_n, busy_n;

    logic signed [PW-1:0] in_ext, g_ext, prod;

`ifdef MUTE_ZC_WAIT_EN
    localparam int unsigned WC_W = $clog2(ZC_TIMEOUT + 1);
    logic [WC_W-1:0] wc, wc_n;
    logic            prev_sign;
    logic            zc, tmo;

    // Only the sign of the previous sample matters for crossing detection.
    assign zc  = (muteIn == '0) || (muteIn[15] != prev_sign);
    assign tmo = (wc == WC_W'(ZC_TIMEOUT - 1));
`endif

    always_comb begin
        in_ext = {{(PW-16){muteIn[15]}}, muteIn};
        g_ext  = {{(PW-L-1){1'b0}}, g};
        prod   = in_ext * g_ext;
    end

    always_comb begin
        state_n = state;
        g_n     = g;
`ifdef MUTE_ZC_WAIT_EN
        wc_n    = wc;
`endif
        case (state)
            UNMUTED: begin
                if (mute) begin
`ifdef MUTE_ZC_WAIT_EN
                    state_n = WAIT_DN;
                    wc_n    = '0;
`else
                    state_n = RAMP_DN;
`endif
                end
            end
`ifdef MUTE_ZC_WAIT_EN
            WAIT_DN: begin
                if (!mute)           state_n = UNMUTED;
                else if (zc || tmo)  state_n = RAMP_DN;
                else                 wc_n    = wc + WC_W'(1);
            end
            WAIT_UP: begin
                if (mute)            state_n = MUTED;
                else if (zc || tmo)  state_n = RAMP_UP;
                else                 wc_n    = wc + WC_W'(1);
            end
`endif
            // A direction change holds g for that cycle instead of stepping.
            RAMP_DN: begin
                if (!mute) begin
                    state_n = RAMP_UP;
                end else begin
                    g_n = g - G_ONE;
                    if (g == G_ONE) state_n = MUTED;
                end
            end
            MUTED: begin
                if (!mute) begin
`ifdef MUTE_ZC_WAIT_EN
                    state_n = WAIT_UP;
                    wc_n    = '0;
`else
                    state_n = RAMP_UP;
`endif
                end
            end
            RAMP_UP: begin
                if (mute) begin
                    state_n = RAMP_DN;
                end else begin
                    g_n = g + G_ONE;
                    if (g == G_TOP) state_n = UNMUTED;
                end
            end
            default: begin
                state_n = MUTED;
                g_n     = '0;
            end
        endcase
        muted_n = (state_n == MUTED);
        busy_n  = (state_n != MUTED) && (state_n != UNMUTED);
    end

    always_ff @(posedge clk_48) begin
        if (reset) begin
            state   <= MUTED;
            g       <= '0;
            muteOut <= '0;
            muted   <= 1'b1;
            busy    <= 1'b0;
`ifdef MUTE_ZC_WAIT_EN
            wc        <= '0;
            prev_sign <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            g       <= g_n;
            muteOut <= 16'(prod >>> L);
            muted   <= muted_n;
            busy    <= busy_n;
`ifdef MUTE_ZC_WAIT_EN
            wc        <= wc_n;
            prev_sign <= muteIn[15];
`endif
        end
    end

endmodule

// File: tb/tb_mute_ramp_ctrl.sv
// Directed bench for mute_ramp_ctrl; muteIn = 64 makes muteOut equal the gain held before each edge.
// Wait-state steps are included when MUTE_ZC_WAIT_EN is defined.
module tb_mute_ramp_ctrl;

    localparam int unsigned L  = 6;
    localparam int unsigned ZC = 480;

    logic               clk_48 = 1'b0;
    logic               reset;
    logic               mute;
    logic signed [15:0] muteIn;
    logic signed [15:0] muteOut;
    logic               muted;
    logic               busy;

    int vectors = 0;
    int errors  = 0;

    mute_ramp_ctrl #(
        .RAMP_LEN_LOG2(L),
        .ZC_TIMEOUT   (ZC)
    ) dut (
        .clk_48 (clk_48),
        .reset  (reset),
        .mute   (mute),
        .muteIn (muteIn),
        .muteOut(muteOut),
        .muted  (muted),
        .busy   (busy)
    );

    always #5 clk_48 = ~clk_48;

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk_48);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        mute   = 1'b1;
        muteIn = 16'sd64;
        step(1);
        check("rst_out",   muteOut, 0);
        check("rst_muted", muted,   1);
        check("rst_busy",  busy,    0);
        reset = 1'b0;
        step(2);
        check("hold_muted", muted, 1);
        check("hold_busy",  busy,  0);

        // Unmute from the power-up state; constant positive input never crosses zero.
        mute = 1'b0;
        step(1);
        check("unm_busy",  busy,  1);
        check("unm_muted", muted, 0);
`ifdef MUTE_ZC_WAIT_EN
        step(ZC - 1);
        check("tmo_busy", busy,    1);
        check("tmo_out",  muteOut, 0);
        step(1);
`endif
        check("up_g0", muteOut, 0);
        step(33);
        check("up_g32", muteOut, 32);
        step(31);
        check("up_end_out",  muteOut, 63);
        check("up_end_busy", busy,    0);
        check("up_end_mute", muted,   0);
        step(1);
        check("unity", muteOut, 64);

        muteIn = 16'sd32767;
        step(1);
        check("g64_pos_max", muteOut, 32767);
        muteIn = -16'sd32768;
        step(1);
        check("g64_neg_max", muteOut, -32768);
        muteIn = 16'sd1000;
        step(1);
        check("g64_1000", muteOut, 1000);
        muteIn = 16'sd64;
        step(1);

        // Mute, then abort at g=32.
        mute = 1'b1;
        step(1);
`ifdef MUTE_ZC_WAIT_EN
        check("wdn_out", muteOut, 64);
        muteIn = -16'sd64;
        step(1);
        check("zc_out", muteOut, -64);
        muteIn = 16'sd64;
`endif
        check("dn_busy",  busy,  1);
        check("dn_muted", muted, 0);
        step(1);
        check("dn_g64", muteOut, 64);
        step(31);
        check("dn_g33", muteOut, 33);
        mute   = 1'b0;
        muteIn = -16'sd32768;
        step(1);
        check("g32_neg_max", muteOut, -16384);
        check("abort_busy",  busy,    1);
        muteIn = 16'sd64;
        step(1);
        check("abort_hold", muteOut, 32);
        step(31);
        check("abort_end_out",  muteOut, 63);
        check("abort_end_busy", busy,    0);
        step(1);
        check("abort_unity", muteOut, 64);

        // Full mute down to g=0 with the floor corner at g=1.
        mute = 1'b1;
        step(1);
`ifdef MUTE_ZC_WAIT_EN
        muteIn = -16'sd64;
        step(1);
        muteIn = 16'sd64;
`endif
        step(63);
        check("dn_g2", muteOut, 2);
        check("dn_g2_muted", muted, 0);
        muteIn = -16'sd1;
        step(1);
        check("g1_floor",  muteOut, -1);
        check("end_muted", muted,   1);
        check("end_busy",  busy,    0);
        muteIn = 16'sd64;
        step(1);
        check("g0_out", muteOut, 0);

        // Reset in the middle of an up ramp.
        mute = 1'b0;
        step(1);
`ifdef MUTE_ZC_WAIT_EN
        muteIn = -16'sd64;
        step(1);
        muteIn = 16'sd64;
`endif
        step(40);
        check("up40_out",  muteOut, 39);
        check("up40_busy", busy,    1);
        reset = 1'b1;
        step(1);
        check("mid_rst_out",   muteOut, 0);
        check("mid_rst_muted", muted,   1);
        check("mid_rst_busy",  busy,    0);
        reset = 1'b0;
        mute  = 1'b1;
        step(1);
        check("post_rst_out",   muteOut, 0);
        check("post_rst_muted", muted,   1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
